// File: rtl/perceptron_pkg.sv
// Shared definitions for the bit-serial perceptron classifier.
// Contents: FSM state encoding, a constant-foldable clog2 helper, the
// weight-port address-width helper and the Q1.7 weight range constants.
package perceptron_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StAccum,
    StDecide,
    StDone,
    StUpdate
  } state_e;

  // Range of a default-width (8-bit, Q1.7) weight.
  localparam int W_MAX = 127;
  localparam int W_MIN = -128;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

  // Address width used for the weight port; never narrower than one bit.
  function automatic int addr_width(input int n);
    return (clog2(n) < 1) ? 1 : clog2(n);
  endfunction

endpackage

// File: rtl/perceptron_serial_if.sv
// Handshake/bus bundle of perceptron_serial.
// Feature input (in_valid/in_ready/features), weight and bias write port
// (wt_we/wt_addr/wt_data/bias_we) and result output
// (out_valid/out_ready/classification/score).
// With PERCEPTRON_LEARN_EN defined it also carries label (in) and updated (out).
// master: the side driving features and writes; slave: the classifier.
interface perceptron_serial_if #(
  parameter int N_INPUTS  = 8,
  parameter int W_WIDTH   = 8,
  parameter int ACC_WIDTH = 12
);
  localparam int AW = perceptron_pkg::addr_width(N_INPUTS);

  logic                        in_valid;
  logic                        in_ready;
  logic [N_INPUTS-1:0]         features;
  logic                        wt_we;
  logic [AW-1:0]               wt_addr;
  logic signed [W_WIDTH-1:0]   wt_data;
  logic                        bias_we;
  logic                        out_valid;
  logic                        out_ready;
  logic                        classification;
  logic signed [ACC_WIDTH-1:0] score;
`ifdef PERCEPTRON_LEARN_EN
  logic                        label;
  logic                        updated;

  modport master (
    output in_valid, features, wt_we, wt_addr, wt_data, bias_we, out_ready, label,
    input  in_ready, out_valid, classification, score, updated
  );
  modport slave (
    input  in_valid, features, wt_we, wt_addr, wt_data, bias_we, out_ready, label,
    output in_ready, out_valid, classification, score, updated
  );
`else
  modport master (
    output in_valid, features, wt_we, wt_addr, wt_data, bias_we, out_ready,
    input  in_ready, out_valid, classification, score
  );
  modport slave (
    input  in_valid, features, wt_we, wt_addr, wt_data, bias_we, out_ready,
    output in_ready, out_valid, classification, score
  );
`endif

endinterface

// File: rtl/sat_add.sv
// Signed saturating adder of width WIDTH.
// Ports: a_i, b_i  signed addends; sum_o  a_i + b_i clamped to the signed range.
module sat_add #(
  parameter int unsigned WIDTH = 8
) (
  input  logic signed [WIDTH-1:0] a_i,
  input  logic signed [WIDTH-1:0] b_i,
  output logic signed [WIDTH-1:0] sum_o
);

  logic [WIDTH:0] full;

  always_comb begin
    full = {a_i[WIDTH-1], a_i} + {b_i[WIDTH-1], b_i};
    // Overflow iff the extra sign bit disagrees with the result sign bit.
    if (full[WIDTH] != full[WIDTH-1]) begin
      sum_o = full[WIDTH] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    end else begin
      sum_o = full[WIDTH-1:0];
    end
  end

endmodule

// File: rtl/perceptron_serial.sv
// Bit-serial single-layer perceptron classifier.
// Accepts a binary feature vector, accumulates one weight per cycle for each set
// feature (saturating), adds the bias and compares with THRESH.
// Ports: clk, rst_n (synchronous, active-low); bus (perceptron_serial_if.slave):
//   feature handshake, weight/bias write port (IDLE only), result handshake.
// Optional: define PERCEPTRON_LEARN_EN to add label/updated and the UPDATE
//   state that nudges weights and bias by LR on a misprediction.
module perceptron_serial
  import perceptron_pkg::*;
#(
  parameter int N_INPUTS  = 8,
  parameter int W_WIDTH   = 8,
  parameter int ACC_WIDTH = 12,
  parameter int W_RESET   = 64,
  parameter int THRESH    = 64,
  parameter int LR        = 8
) (
  input logic                clk,
  input logic                rst_n,
  perceptron_serial_if.slave bus
);

  localparam int AW = addr_width(N_INPUTS);
  localparam logic signed [ACC_WIDTH-1:0] ThreshS = ACC_WIDTH'(THRESH);
  localparam logic [AW-1:0] LastIdx = AW'(N_INPUTS - 1);

  state_e                      state_q, state_d;
  logic [N_INPUTS-1:0]         feat_q, feat_d;
  logic [AW-1:0]               idx_q, idx_d;
  logic signed [ACC_WIDTH-1:0] acc_q, acc_d;
  logic signed [ACC_WIDTH-1:0] score_q, score_d;
  logic                        class_q, class_d;
  logic signed [W_WIDTH-1:0]   w_q [N_INPUTS];
  logic signed [W_WIDTH-1:0]   w_d [N_INPUTS];
  logic signed [W_WIDTH-1:0]   bias_q, bias_d;

  logic signed [W_WIDTH-1:0]   w_cur;
  logic signed [ACC_WIDTH-1:0] w_ext, bias_ext, acc_sum, score_sum;
  logic                        last_idx, addr_ok;

  assign w_cur    = w_q[idx_q];
  assign w_ext    = {{(ACC_WIDTH-W_WIDTH){w_cur[W_WIDTH-1]}}, w_cur};
  assign bias_ext = {{(ACC_WIDTH-W_WIDTH){bias_q[W_WIDTH-1]}}, bias_q};
  assign last_idx = (idx_q == LastIdx);
  assign addr_ok  = (int'(bus.wt_addr) < N_INPUTS);

  sat_add #(.WIDTH(ACC_WIDTH)) u_acc_add (
    .a_i  (acc_q),
    .b_i  (w_ext),
    .sum_o(acc_sum)
  );

  sat_add #(.WIDTH(ACC_WIDTH)) u_bias_add (
    .a_i  (acc_q),
    .b_i  (bias_ext),
    .sum_o(score_sum)
  );

`ifdef PERCEPTRON_LEARN_EN
  localparam logic signed [W_WIDTH-1:0] LrS = W_WIDTH'(LR);

  logic                      label_q, label_d;
  logic                      upd_q, upd_d;
  logic signed [W_WIDTH-1:0] step, w_new, bias_new;

  assign step = label_q ? LrS : -LrS;

  sat_add #(.WIDTH(W_WIDTH)) u_w_upd (
    .a_i  (w_cur),
    .b_i  (step),
    .sum_o(w_new)
  );

  sat_add #(.WIDTH(W_WIDTH)) u_b_upd (
    .a_i  (bias_q),
    .b_i  (step),
    .sum_o(bias_new)
  );

  assign bus.updated = upd_q;
`endif

  always_comb begin
    state_d = state_q;
    feat_d  = feat_q;
    idx_d   = idx_q;
    acc_d   = acc_q;
    score_d = score_q;
    class_d = class_q;
    w_d     = w_q;
    bias_d  = bias_q;
`ifdef PERCEPTRON_LEARN_EN
    label_d = label_q;
    upd_d   = upd_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (bus.wt_we && addr_ok) w_d[bus.wt_addr] = bus.wt_data;
        if (bus.bias_we) bias_d = bus.wt_data;
        if (bus.in_valid) begin
          feat_d  = bus.features;
          acc_d   = '0;
          idx_d   = '0;
          state_d = StAccum;
`ifdef PERCEPTRON_LEARN_EN
          label_d = bus.label;
`endif
        end
      end
      StAccum: begin
        if (feat_q[idx_q]) acc_d = acc_sum;
        if (last_idx) begin
          idx_d   = '0;
          state_d = StDecide;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      StDecide: begin
        score_d = score_sum;
        class_d = (score_sum >= ThreshS);
        state_d = StDone;
`ifdef PERCEPTRON_LEARN_EN
        upd_d = ((score_sum >= ThreshS) != label_q);
        if ((score_sum >= ThreshS) != label_q) state_d = StUpdate;
`endif
      end
`ifdef PERCEPTRON_LEARN_EN
      StUpdate: begin
        if (feat_q[idx_q]) w_d[idx_q] = w_new;
        // Bias moves once per update pass, on the first slot.
        if (idx_q == '0) bias_d = bias_new;
        if (last_idx) begin
          idx_d   = '0;
          state_d = StDone;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
`endif
      StDone: begin
        if (bus.out_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
      feat_q  <= '0;
      idx_q   <= '0;
      acc_q   <= '0;
      score_q <= '0;
      class_q <= 1'b0;
      bias_q  <= '0;
      for (int i = 0; i < N_INPUTS; i++) w_q[i] <= W_WIDTH'(W_RESET);
`ifdef PERCEPTRON_LEARN_EN
      label_q <= 1'b0;
      upd_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      feat_q  <= feat_d;
      idx_q   <= idx_d;
      acc_q   <= acc_d;
      score_q <= score_d;
      class_q <= class_d;
      bias_q  <= bias_d;
      w_q     <= w_d;
`ifdef PERCEPTRON_LEARN_EN
      label_q <= label_d;
      upd_q   <= upd_d;
`endif
    end
  end

  assign bus.in_ready       = (state_q == StIdle);
  assign bus.out_valid      = (state_q == StDone);
  assign bus.score          = score_q;
  assign bus.classification = class_q;

endmodule

// File: tb/tb_perceptron_serial.sv
// Directed bench for perceptron_serial: two instances sharing stimulus, one with
// ACC_WIDTH=12 (a) and one with ACC_WIDTH=9 (b) for accumulator saturation.
module tb_perceptron_serial;
  import perceptron_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic       in_valid, out_ready, wt_we, bias_we, label;
  logic [7:0] features;
  logic [2:0] wt_addr;
  logic [7:0] wt_data;

  perceptron_serial_if #(.N_INPUTS(8), .W_WIDTH(8), .ACC_WIDTH(12)) bus_a ();
  perceptron_serial_if #(.N_INPUTS(8), .W_WIDTH(8), .ACC_WIDTH(9))  bus_b ();

  assign bus_a.in_valid  = in_valid;
  assign bus_a.features  = features;
  assign bus_a.wt_we     = wt_we;
  assign bus_a.wt_addr   = wt_addr;
  assign bus_a.wt_data   = wt_data;
  assign bus_a.bias_we   = bias_we;
  assign bus_a.out_ready = out_ready;
  assign bus_b.in_valid  = in_valid;
  assign bus_b.features  = features;
  assign bus_b.wt_we     = wt_we;
  assign bus_b.wt_addr   = wt_addr;
  assign bus_b.wt_data   = wt_data;
  assign bus_b.bias_we   = bias_we;
  assign bus_b.out_ready = out_ready;
`ifdef PERCEPTRON_LEARN_EN
  assign bus_a.label = label;
  assign bus_b.label = label;
`endif

  perceptron_serial #(
    .N_INPUTS(8), .W_WIDTH(8), .ACC_WIDTH(12), .W_RESET(64), .THRESH(64), .LR(8)
  ) u_dut_a (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus_a.slave)
  );

  perceptron_serial #(
    .N_INPUTS(8), .W_WIDTH(8), .ACC_WIDTH(9), .W_RESET(64), .THRESH(64), .LR(8)
  ) u_dut_b (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus_b.slave)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
  endtask

  // All tasks start and end just after a falling edge.
  task automatic wr_w(input int addr, input int val);
    wt_we   = 1'b1;
    wt_addr = 3'(addr);
    wt_data = 8'(val);
    @(negedge clk);
    wt_we = 1'b0;
  endtask

  task automatic wr_b(input int val);
    bias_we = 1'b1;
    wt_data = 8'(val);
    @(negedge clk);
    bias_we = 1'b0;
  endtask

  // Presents one vector; lat is the rising edge (counted from the accept edge)
  // at which out_valid is first seen high. wr_at > 0 fires a weight+bias
  // write on that cycle of the operation.
  task automatic send(input logic [7:0] f, input logic lbl, input int wr_at, output int lat);
    check("in_ready_before_send", int'(bus_a.in_ready), 1);
    features = f;
    label    = lbl;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    lat = 1;
    while (!bus_a.out_valid && lat < 60) begin
      if (lat == wr_at) begin
        wt_we   = 1'b1;
        bias_we = 1'b1;
        wt_addr = 3'd3;
        wt_data = 8'd100;
      end
      @(negedge clk);
      wt_we   = 1'b0;
      bias_we = 1'b0;
      lat++;
    end
    if (out_ready) @(negedge clk);
  endtask

  int lat;
  int sc_hold, cl_hold, seen;

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; wt_we = 1'b0; bias_we = 1'b0;
    label = 1'b0; features = '0; wt_addr = '0; wt_data = '0;
    @(negedge clk);
    @(negedge clk);
    check("rst_in_ready", int'(bus_a.in_ready), 1);
    check("rst_out_valid", int'(bus_a.out_valid), 0);
    check("rst_score", int'(bus_a.score), 0);
    check("rst_class", int'(bus_a.classification), 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Defaults: one feature -> 64 >= 64.
    send(8'h01, 1'b1, 0, lat);
    check("lat_f01", lat, 10);
    check("score_f01", int'(bus_a.score), 64);
    check("class_f01", int'(bus_a.classification), 1);
    send(8'h00, 1'b0, 0, lat);
    check("score_f00", int'(bus_a.score), 0);
    check("class_f00", int'(bus_a.classification), 0);
    check("out_valid_drops", int'(bus_a.out_valid), 0);

    wr_w(3, -128);
    wr_b(-16);
    send(8'h08, 1'b0, 0, lat);
    check("score_w3", int'(bus_a.score), -144);
    check("class_w3", int'(bus_a.classification), 0);
    check("score_w3_b", int'(bus_b.score), -144);
    // Writes while accumulating must not land.
    send(8'h08, 1'b0, 2, lat);
    check("score_wr_accum", int'(bus_a.score), -144);
    send(8'h08, 1'b0, 0, lat);
    check("score_wr_after", int'(bus_a.score), -144);
    check("class_wr_after", int'(bus_a.classification), 0);

    // Saturation.
    wr_b(0);
    for (int i = 0; i < 8; i++) wr_w(i, W_MAX);
    send(8'hFF, 1'b1, 0, lat);
    check("score_max_a", int'(bus_a.score), 1016);
    check("score_max_b", int'(bus_b.score), 255);
    check("class_max_b", int'(bus_b.classification), 1);
    for (int i = 0; i < 8; i++) wr_w(i, W_MIN);
    send(8'hFF, 1'b0, 0, lat);
    check("score_min_a", int'(bus_a.score), -1024);
    check("score_min_b", int'(bus_b.score), -256);
    check("class_min_b", int'(bus_b.classification), 0);
    // Clamping happens per step: 255 then -4*128 -> -257 -> -256, not -4.
    for (int i = 0; i < 4; i++) wr_w(i, W_MAX);
    send(8'hFF, 1'b0, 0, lat);
    check("score_mix_a", int'(bus_a.score), -4);
    check("score_mix_b", int'(bus_b.score), -256);

    // Backpressure: result held, nothing new accepted.
    out_ready = 1'b0;
    send(8'h0F, 1'b1, 0, lat);
    check("lat_hold", lat, 10);
    sc_hold = int'(bus_a.score);
    cl_hold = int'(bus_a.classification);
    check("score_hold0", sc_hold, 508);
    check("score_hold0_b", int'(bus_b.score), 255);
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      features = 8'hF0;
      @(negedge clk);
      check("hold_valid", int'(bus_a.out_valid), 1);
      check("hold_score", int'(bus_a.score), sc_hold);
      check("hold_class", int'(bus_a.classification), cl_hold);
      check("hold_in_ready", int'(bus_a.in_ready), 0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    check("release_valid", int'(bus_a.out_valid), 0);
    check("release_in_ready", int'(bus_a.in_ready), 1);
    @(negedge clk);
    check("release_still_idle", int'(bus_a.in_ready), 1);

    // Reset in the middle of ACCUM: abort, restore weights and bias.
    features = 8'h0F;
    label    = 1'b1;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus_a.out_valid) seen++;
    end
    check("abort_no_valid", seen, 0);
    check("abort_in_ready", int'(bus_a.in_ready), 1);
    send(8'hFF, 1'b1, 0, lat);
    check("post_rst_score_a", int'(bus_a.score), 512);
    check("post_rst_score_b", int'(bus_b.score), 255);
    send(8'h01, 1'b1, 0, lat);
    check("post_rst_bias", int'(bus_a.score), 64);

`ifdef PERCEPTRON_LEARN_EN
    send(8'h01, 1'b0, 0, lat);
    check("learn_lat", lat, 18);
    check("learn_score", int'(bus_a.score), 64);
    check("learn_class", int'(bus_a.classification), 1);
    check("learn_updated", int'(bus_a.updated), 1);
    send(8'h01, 1'b0, 0, lat);
    check("learn2_lat", lat, 10);
    check("learn2_score", int'(bus_a.score), 48);
    check("learn2_class", int'(bus_a.classification), 0);
    check("learn2_updated", int'(bus_a.updated), 0);
    send(8'h00, 1'b0, 0, lat);
    check("learn_bias", int'(bus_a.score), -8);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/perceptron_serial.md
Name: perceptron_serial

Overview:
Parametrised, bit-serial single-layer perceptron classifier. Accepts an N_INPUTS-bit binary feature vector via valid/ready, multiply-accumulates one feature per cycle against a writable signed weight memory, adds a signed bias and compares the result against a threshold. The classification is returned via valid/ready. Sits between the feature front-end and the decision/IO logic.

Parameters:
N_INPUTS, 8, number of binary features (>=2); one weight per feature
W_WIDTH, 8, weight/bias width; signed Q1.(W_WIDTH-1)
ACC_WIDTH, 12, signed accumulator/score width (> W_WIDTH)
W_RESET, 64, reset value of every weight (0.5 in Q1.7)
THRESH, 64, signed decision threshold in accumulator units
LR, 8, learning step (optional feature only)

Ports:
clk  in  1  clock; all logic on rising edge
rst_n  in  1  reset, synchronous, active-low
in_valid  in  1  feature vector valid
in_ready  out  1  block can accept a vector (high only in IDLE)
features  in  N_INPUTS  binary features; bit i multiplies weight i
wt_we  in  1  weight write strobe
wt_addr  in  clog2(N_INPUTS)  weight index
wt_data  in  W_WIDTH  signed weight value
bias_we  in  1  bias write strobe (uses wt_data)
out_valid  out  1  result valid; held until accepted
out_ready  in  1  downstream accepts result
classification  out  1  1 when score >= THRESH
score  out  ACC_WIDTH  signed saturated acc + bias

Behaviour:
- Reset (rst_n low at a clk edge): state=IDLE, in_ready=1, out_valid=0, classification=0, score=0, acc=0, bias=0, all weights=W_RESET. Reset mid-operation aborts the operation; no output is produced.
- FSM: IDLE -> ACCUM -> DECIDE -> DONE -> IDLE (UPDATE is optional).
- IDLE: in_ready=1. On in_valid&&in_ready at edge T, features are latched, acc=0, idx=0, -> ACCUM.
- ACCUM: one feature per cycle, index 0 first. If features[idx] is set, acc = sat(acc + sign_extend(w[idx])); otherwise acc is unchanged. After idx==N_INPUTS-1 -> DECIDE. Occupies cycles T+1..T+N_INPUTS.
- DECIDE (1 cycle): score = sat(acc + bias); classification = (score >= THRESH), signed compare. Both registered -> DONE.
- DONE: out_valid=1 from cycle T+N_INPUTS+2. score and classification are stable while out_valid=1. On out_ready -> IDLE, out_valid=0 next cycle. in_ready stays low until IDLE is reached, so there is no overlap between operations.
- Latency: handshake-in to out_valid is N_INPUTS+2 cycles. Minimum initiation interval is N_INPUTS+3 cycles with out_ready tied high.
- Saturation: every accumulate clamps to [-2^(ACC_WIDTH-1), 2^(ACC_WIDTH-1)-1]. There is no wrap-around.
- Weight/bias writes apply only in IDLE and take effect at the next edge. Writes in other states are ignored. A wt_addr >= N_INPUTS is ignored. If wt_we and bias_we are both set, both writes apply. A write in the same cycle as an accepted input lands before that vector's ACCUM starts.
- features are ignored except at the accept edge.

Optional Feature:
Macro PERCEPTRON_LEARN_EN.
- Defined: adds input port label (1 bit, latched with features) and output port updated (1 bit, valid with out_valid). After DECIDE, if classification != label, the FSM enters UPDATE for N_INPUTS cycles, index 0 first. For each set feature, w[i] = satW(w[i] + (label ? +LR : -LR)). Bias is adjusted once, the same way, in the first UPDATE cycle. Then -> DONE with updated=1. Latency becomes 2*N_INPUTS+2 on a mispredict; otherwise it is unchanged and updated=0.
- Undefined: no label/updated ports, no UPDATE state, weights change only through writes.

Decomposition:
- Package perceptron_pkg holds: state encoding localparams (IDLE, ACCUM, DECIDE, DONE, UPDATE), the clog2 function, and Q-format constants (W_MAX, W_MIN).
- One sub-module, sat_add: parametrised signed width-WIDTH saturating adder. It is instantiated for the accumulator, the bias add and the weight update.

Test Plan:
- Reset, defaults, features=8'h01 -> out_valid at T+10, score=64, classification=1. features=8'h00 -> score=0, classification=0.
- Write w[3]=-128, bias=-16, features=8'h08 -> score=-144, classification=0. Writes attempted during ACCUM are ignored; the next result is identical.
- ACC_WIDTH=9, all weights=127, features=8'hFF -> score saturates at 255. All weights=-128 -> score=-256.
- Hold out_ready=0 for 5 cycles -> out_valid, score and classification are stable, in_ready=0, and a new in_valid is not accepted. Then out_ready=1 -> IDLE next cycle.
- rst_n low at T+4 mid-ACCUM -> no out_valid. Weights return to 64, bias to 0, and in_ready=1 after reset.
- PERCEPTRON_LEARN_EN: defaults, features=8'h01, label=0 -> classification=1, updated=1, out_valid at T+18, w[0]=56, bias=-8. The same vector repeated -> score=48, classification=0, updated=0.
